sub_bytes_pipe: RTL and testbench
=================================

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning the number of independent byte lanes per word (1..32).
REQ-002 SHALL have parameter OUT_REG, default 1, meaning 1 = registered lookup stage (latency 2) and 0 = lookup bypass (latency 1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous assert and active-low.
REQ-005 SHALL have port in_valid  input  1  meaning the input word is presented.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts the input word this cycle.
REQ-007 SHALL have port in_data  input  8*LANES  meaning the input bytes; lane i occupies bits [8i+7:8i].
REQ-008 SHALL have port in_inv  input  1  meaning 1 = inverse S-box and 0 = forward S-box; sampled with the word.
REQ-009 SHALL have port out_valid  output  1  meaning the result word is presented.
REQ-010 SHALL have port out_ready  input  1  meaning downstream accepts the result.
REQ-011 SHALL have port out_data  output  8*LANES  meaning the substituted bytes in the same lane order.
REQ-012 SHALL have port out_inv  output  1  meaning the mode used for out_data.
REQ-013 SHALL have port busy  output  1  meaning at least one pipeline stage holds a word.

Function
REQ-014 SHALL apply per lane: out byte = InvSbox[b] if the latched mode is 1, else Sbox[b] (FIPS-197 tables); lanes are independent.
REQ-015 SHALL transfer a word when valid and ready are both high on a clock edge, on either side.
REQ-016 SHALL capture in_data and in_inv into stage 1 on an input transfer; the lookup SHALL use the latched value, never the live input.
REQ-017 SHALL, with OUT_REG=1, move stage 1 into stage 2 (table output registered) when stage 2 is empty or stage 2 is transferring out in the same cycle.
REQ-018 SHALL drive in_ready = !s1_valid OR s1 advancing this cycle; in_ready SHALL be independent of in_valid.
REQ-019 SHALL give a latency of exactly OUT_REG+1 cycles from input transfer to out_valid when out_ready is held high, at one word per cycle throughput.
REQ-020 SHALL hold out_data, out_inv and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on a simultaneous output transfer and input transfer with all stages full, accept the new word with no bubble and no loss.
REQ-022 SHALL keep per-word mode: words of mixed in_inv SHALL never take another word's mode.
REQ-023 SHALL drive busy = OR of all stage valid bits.
REQ-024 SHALL preserve word order; no word is dropped or duplicated.

Reset
REQ-025 SHALL, on rst_n low, clear all stage valid bits immediately, giving out_valid=0 and busy=0; in_ready SHALL be 1 during and after reset.
REQ-026 SHALL reset out_data to 0 and out_inv to 0.
REQ-027 SHALL discard words in flight when reset asserts mid-operation; the first post-reset transfer SHALL be accepted on the first edge after rst_n rises.

Configuration
REQ-028 SHALL include the forward S-box table only when macro SBOX_FWD_EN is defined.
REQ-029 SHALL, without SBOX_FWD_EN, treat in_inv as 1 for every word (inverse-only, forward table absent) and drive out_inv=1 for every result.

Verification
REQ-030 SHALL cover: LANES=4, in_data=32'hFF63_0052 with in_inv=1 -> out_data=32'h7D00_5248 after 2 cycles.
REQ-031 SHALL cover: SBOX_FWD_EN defined, in_data=32'hFF53_0000 with in_inv=0 -> out_data=32'h16ED_6363; the same word with SBOX_FWD_EN undefined -> inverse result with out_inv=1.
REQ-032 SHALL cover: 8 back-to-back words with alternating in_inv and out_ready=1 -> 8 results on consecutive cycles with correct per-word modes.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with 3 words offered -> exactly 2 accepted (OUT_REG=1), then in_ready=0 and outputs stable; after release, 3 results in order.
REQ-034 SHALL cover: rst_n pulsed low with 2 words in flight -> out_valid=0 and busy=0 immediately, and no stale word appears afterwards.
REQ-035 SHALL cover: OUT_REG=0, random traffic and random out_ready over 10k words -> latency 1 and every byte matching a reference table model.

Source files
------------

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: per-lane AES SubBytes / InvSubBytes with a valid/ready pipeline.
// Define SBOX_FWD_EN to build in the forward S-box; without it the block is inverse-only.
module sub_bytes_pipe #(
  parameter int LANES   = 16,
  parameter int OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic               busy
);

  // Entry 0 sits in the top byte of each table.
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_lut(input logic [7:0] b);
    return INV_TBL[{~b, 3'b000} +: 8];
  endfunction

`ifdef SBOX_FWD_EN
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_lut(input logic [7:0] b);
    return FWD_TBL[{~b, 3'b000} +: 8];
  endfunction
`endif

  logic               s1_valid_reg;
  logic [8*LANES-1:0] s1_data_reg;
  logic               s1_inv_reg;
  logic [8*LANES-1:0] lut_data;
  logic               s1_adv;
  logic               in_fire;
  logic               mode_in;

`ifdef SBOX_FWD_EN
  assign mode_in = in_inv;
`else
  // Inverse-only build: every word is forced to inverse mode.
  assign mode_in = in_inv | 1'b1;
`endif

  assign in_ready = !s1_valid_reg || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_inv_reg   <= 1'b0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_data_reg  <= in_data;
      s1_inv_reg   <= mode_in;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Lookup always works from the latched word and its latched mode.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef SBOX_FWD_EN
      assign lut_data[8*gi +: 8] = s1_inv_reg ? inv_lut(s1_data_reg[8*gi +: 8])
                                              : fwd_lut(s1_data_reg[8*gi +: 8]);
`else
      assign lut_data[8*gi +: 8] = inv_lut(s1_data_reg[8*gi +: 8]);
`endif
    end
  endgenerate

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic               s2_valid_reg;
      logic [8*LANES-1:0] s2_data_reg;
      logic               s2_inv_reg;
      logic               out_fire;

      assign out_fire = s2_valid_reg && out_ready;
      assign s1_adv   = s1_valid_reg && (!s2_valid_reg || out_ready);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
          s2_inv_reg   <= 1'b0;
        end else if (s1_adv) begin
          s2_valid_reg <= 1'b1;
          s2_data_reg  <= lut_data;
          s2_inv_reg   <= s1_inv_reg;
        end else if (out_fire) begin
          s2_valid_reg <= 1'b0;
        end
      end

      assign out_valid = s2_valid_reg;
      assign out_data  = s2_data_reg;
      assign out_inv   = s2_inv_reg;
      assign busy      = s1_valid_reg | s2_valid_reg;
    end else begin : g_bypass
      // Outputs are gated so an empty stage presents zeros, matching reset.
      assign s1_adv    = s1_valid_reg && out_ready;
      assign out_valid = s1_valid_reg;
      assign out_data  = s1_valid_reg ? lut_data : '0;
      assign out_inv   = s1_valid_reg & s1_inv_reg;
      assign busy      = s1_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: directed vectors on a 4-lane registered instance and
// randomized traffic on a 16-lane bypass instance against a GF(2^8) reference model.
module tb_sub_bytes_pipe;
  localparam int LA = 4;
  localparam int LB = 16;
  localparam int NWORDS = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_in_valid = 1'b0, a_in_inv = 1'b0, a_out_ready = 1'b1;
  logic [8*LA-1:0] a_in_data = '0;
  logic            a_in_ready, a_out_valid, a_out_inv, a_busy;
  logic [8*LA-1:0] a_out_data;

  logic            b_in_valid = 1'b0, b_in_inv = 1'b0, b_out_ready = 1'b1;
  logic [8*LB-1:0] b_in_data = '0;
  logic            b_in_ready, b_out_valid, b_out_inv, b_busy;
  logic [8*LB-1:0] b_out_data;

  sub_bytes_pipe #(.LANES(LA), .OUT_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_inv(a_out_inv), .busy(a_busy)
  );

  sub_bytes_pipe #(.LANES(LB), .OUT_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a;
    p = '0;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse, then the AES affine map.
  task automatic build_ref();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] x, s, t;
      x = 8'(v);
      s = 8'h00;
      if (x != 8'h00) begin
        s = 8'h01;
        repeat (254) s = gf_mul(s, x);
      end
      t = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
      ref_fwd[v] = t;
      ref_inv[t] = x;
    end
  endtask

  function automatic logic eff_mode(input logic inv);
`ifdef SBOX_FWD_EN
    return inv;
`else
    return 1'b1 | inv;
`endif
  endfunction

  function automatic logic [127:0] exp_word(input logic [127:0] d, input logic inv, input int lanes);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++)
      r[8*i +: 8] = inv ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
    return r;
  endfunction

  typedef struct {
    logic [31:0] din;
    logic        inv;
    logic [31:0] dout;
    logic        oinv;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic         inv;
    int           acc;
  } sb_t;

  vec_t vecs[5];
  sb_t  q[$];

  initial begin
    logic [127:0] e;
    logic [31:0]  w[8];
    logic         wi[8];
    int got, first, acc, sent, recv, cyc, head_seen;

    build_ref();

    vecs[0] = '{32'hFF63_0052, 1'b1, 32'h7D00_5248, 1'b1};
`ifdef SBOX_FWD_EN
    vecs[1] = '{32'hFF53_0000, 1'b0, 32'h16ED_6363, 1'b0};
    vecs[3] = '{32'h6363_6363, 1'b0, 32'hFBFB_FBFB, 1'b0};
`else
    vecs[1] = '{32'hFF53_0000, 1'b0, 32'h7D50_5252, 1'b1};
    vecs[3] = '{32'h6363_6363, 1'b0, 32'h0000_0000, 1'b1};
`endif
    vecs[2] = '{32'h0000_0000, 1'b1, 32'h5252_5252, 1'b1};
    vecs[4] = '{32'h0102_0304, 1'b1, 32'h096A_D530, 1'b1};

    // Reset state while rst_n is low.
    #3;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_inv", a_out_inv, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_out_data", b_out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single words, latency 2, inputs scrambled after transfer.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = vecs[k].din;
      a_in_inv   = vecs[k].inv;
      @(negedge clk);
      check("vec_in_ready", a_in_ready, 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_in_data  = $urandom;
      a_in_inv   = ~vecs[k].inv;
      @(negedge clk);
      check("vec_lat1_valid", a_out_valid, 0);
      check("vec_lat1_busy", a_busy, 1);
      @(negedge clk);
      check("vec_out_valid", a_out_valid, 1);
      check("vec_out_data", a_out_data, vecs[k].dout);
      check("vec_out_inv", a_out_inv, vecs[k].oinv);
      $display("vec %0d in=%h inv=%0d -> out=%h out_inv=%0d", k, vecs[k].din, vecs[k].inv,
               a_out_data, a_out_inv);
    end

    // Eight back-to-back words with alternating modes.
    for (int k = 0; k < 8; k++) begin
      w[k]  = $urandom;
      wi[k] = k[0];
    end
    got = 0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        a_in_valid = 1'b1;
        a_in_data  = w[c];
        a_in_inv   = wi[c];
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) check("b2b_in_ready", a_in_ready, 1);
      if (a_out_valid) begin
        if (got == 0) first = c;
        if (got < 8) begin
          e = exp_word(128'(w[got]), eff_mode(wi[got]), LA);
          check("b2b_data", a_out_data, e[31:0]);
          check("b2b_inv", a_out_inv, eff_mode(wi[got]));
          check("b2b_slot", c, first + got);
          $display("b2b word %0d in=%h inv=%0d -> out=%h out_inv=%0d", got, w[got], wi[got],
                   a_out_data, a_out_inv);
        end
        got++;
      end
    end
    check("b2b_first_cycle", first, 2);
    check("b2b_count", got, 8);

    // Output stall: three words offered, only two fit.
    for (int k = 0; k < 3; k++) begin
      w[k]  = $urandom;
      wi[k] = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    acc = 0;
    a_in_valid = 1'b1;
    a_in_data  = w[0];
    a_in_inv   = wi[0];
    e = exp_word(128'(w[0]), eff_mode(wi[0]), LA);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("stall_in_ready", a_in_ready, 0);
        check("stall_out_valid", a_out_valid, 1);
        check("stall_out_data", a_out_data, e[31:0]);
        check("stall_out_inv", a_out_inv, eff_mode(wi[0]));
      end
      if (a_in_valid && a_in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 3) begin
        a_in_data = w[acc];
        a_in_inv  = wi[acc];
      end else begin
        a_in_valid = 1'b0;
      end
    end
    check("stall_accepted", acc, 2);
    a_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_out_valid && a_out_ready) begin
        if (got < 3) begin
          e = exp_word(128'(w[got]), eff_mode(wi[got]), LA);
          check("stall_rel_data", a_out_data, e[31:0]);
          check("stall_rel_inv", a_out_inv, eff_mode(wi[got]));
          $display("stall word %0d in=%h -> out=%h", got, w[got], a_out_data);
        end
        got++;
      end
      if (a_in_valid && a_in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 3) begin
        a_in_data = w[acc];
        a_in_inv  = wi[acc];
      end else begin
        a_in_valid = 1'b0;
      end
    end
    check("stall_results", got, 3);

    // Reset with two words in flight.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = $urandom;
    @(posedge clk); #1;
    a_in_data = $urandom;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_in_ready", a_in_ready, 1);
    check("midrst_out_data", a_out_data, 0);
    check("midrst_out_inv", a_out_inv, 0);
    @(posedge clk); #1;
    check("midrst_in_ready_hold", a_in_ready, 1);
    w[0] = 32'hA5C3_1E00;
    a_in_valid  = 1'b1;
    a_in_data   = w[0];
    a_in_inv    = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("postrst_lat1_valid", a_out_valid, 0);
    check("postrst_busy", a_busy, 1);
    @(negedge clk);
    e = exp_word(128'(w[0]), 1'b1, LA);
    check("postrst_out_valid", a_out_valid, 1);
    check("postrst_out_data", a_out_data, e[31:0]);
    $display("post-reset word in=%h -> out=%h", w[0], a_out_data);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_stale", a_out_valid, 0);
    end

    // Random traffic on the bypass instance against the reference model.
    sent = 0;
    recv = 0;
    cyc = 0;
    head_seen = -1;
    while ((sent < NWORDS || q.size() != 0) && cyc < 60000) begin
      @(posedge clk); #1;
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < NWORDS) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        b_in_data  = {$urandom, $urandom, $urandom, $urandom};
        b_in_inv   = 1'($urandom_range(0, 1));
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      check("rand_busy", b_busy, q.size() != 0);
      if (b_out_valid) begin
        if (q.size() == 0) begin
          check("rand_spurious", b_out_valid, 0);
        end else begin
          if (head_seen < 0) begin
            head_seen = cyc;
            check("rand_latency", cyc - q[0].acc, 1);
          end
          if (b_out_ready) begin
            check("rand_data", b_out_data, exp_word(q[0].d, q[0].inv, LB));
            check("rand_inv", b_out_inv, q[0].inv);
            void'(q.pop_front());
            head_seen = -1;
            recv++;
          end
        end
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back('{b_in_data, eff_mode(b_in_inv), cyc});
        sent++;
      end
      cyc++;
    end
    check("rand_received", recv, NWORDS);
    $display("random phase: %0d words sent, %0d received in %0d cycles", sent, recv, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
